// File: rtl/esp32_io_conditioner_pkg.sv
// rtl/esp32_io_conditioner_pkg.sv - shared defaults, per-bit status type and counter sizing helper
package esp32_io_conditioner_pkg;

  // Defaults shared by the conditioner and the PIO wrapper so both stay the same width
  localparam int ESP_IO_WIDTH           = 3;
  localparam int ESP_IO_SYNC_STAGES     = 2;
  localparam int ESP_IO_DEBOUNCE_CYCLES = 50000;

  // One conditioned line: settled level plus single-cycle edge strobes
  typedef struct packed {
    logic clean;
    logic rise;
    logic fall;
  } bit_status_t;

  // Counter width able to hold DEBOUNCE_CYCLES; never narrower than one bit
  function automatic int cnt_width(input int cycles);
    return (cycles < 1) ? 1 : $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/esp32_io_debounce_bit.sv
// rtl/esp32_io_debounce_bit.sv - one line: synchroniser, debounce counter, clean level and edge strobes
module esp32_io_debounce_bit
  import esp32_io_conditioner_pkg::*;
#(
  parameter int SYNC_STAGES     = ESP_IO_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = ESP_IO_DEBOUNCE_CYCLES
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        pin,
  output bit_status_t status
);

  localparam int             CW       = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   synced;
  logic [CW-1:0]          cnt;
  logic                   clean_q;
  logic                   accept;

  // Plain shift chain; nothing may sit between stages or metastability can leak through
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pin};
    end
  end

  assign synced = sync_q[SYNC_STAGES-1];

  // The new level is taken on the DEBOUNCE_CYCLES-th consecutive mismatching cycle
  assign accept = (synced != clean_q) && (cnt == CNT_LAST);

  // Count consecutive mismatches; any agreement with the current level restarts from zero
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt     <= '0;
      clean_q <= 1'b0;
    end else if (synced == clean_q) begin
      cnt     <= '0;
    end else if (accept) begin
      clean_q <= synced;
      cnt     <= '0;
    end else begin
      cnt     <= cnt + 1'b1;
    end
  end

  // Strobes are high in the cycle before clean changes, so sticky flags set on the same edge
  assign status = {clean_q, accept & synced, accept & ~synced};

endmodule

// File: rtl/esp32_io_conditioner.sv
// rtl/esp32_io_conditioner.sv - debounced ESP32 status lines with sticky edge events and irq
module esp32_io_conditioner
  import esp32_io_conditioner_pkg::*;
#(
  parameter int WIDTH           = ESP_IO_WIDTH,
  parameter int SYNC_STAGES     = ESP_IO_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = ESP_IO_DEBOUNCE_CYCLES
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] esp_in,
  input  logic [WIDTH-1:0] clr_events,
  output logic [WIDTH-1:0] clean_out,
  output logic [WIDTH-1:0] rise_evt,
  output logic [WIDTH-1:0] fall_evt,
  output logic             irq
);

  logic [WIDTH-1:0] rise_set;
  logic [WIDTH-1:0] fall_set;

  for (genvar g = 0; g < WIDTH; g++) begin : g_bit
    bit_status_t st;

    esp32_io_debounce_bit #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk     (clk),
      .reset_n (reset_n),
      .pin     (esp_in[g]),
      .status  (st)
    );

    assign clean_out[g] = st.clean;
    assign rise_set[g]  = st.rise;
    assign fall_set[g]  = st.fall;
  end

  // Sticky flags: a new edge outranks a clear on the same cycle so no event is ever dropped
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rise_evt <= '0;
      fall_evt <= '0;
    end else begin
      rise_evt <= rise_set | (rise_evt & ~clr_events);
      fall_evt <= fall_set | (fall_evt & ~clr_events);
    end
  end

  // Built only from registered flags, so the interrupt line cannot glitch
  assign irq = |(rise_evt | fall_evt);

endmodule
